// File: rtl/scan_bus_arb.sv
// Round-robin arbiter sharing the mem_reg_mux scan access port between the
// scan-chain controller (req0) and the boot/debug loader (req1).
module scan_bus_arb #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_wen,
   input  logic              req0_ren,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_wen,
   input  logic              req1_ren,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              scan_wen,
   output logic              scan_ren,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_wdata,
   input  logic [DATA_W-1:0] scan_rdata,
   input  logic              scan_ready,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
   localparam bit          TMO_EN   = (TIMEOUT != 0);

   state_t              state_r;
   logic                rr_r;
   logic [15:0]         timer_r;
   logic                grant_r;
   logic                busy_r;
   logic                scan_wen_r;
   logic                scan_ren_r;
   logic [ADDR_W-1:0]   scan_addr_r;
   logic [DATA_W-1:0]   scan_wdata_r;
   logic                req0_done_r;
   logic                req1_done_r;
   logic                req0_err_r;
   logic                req1_err_r;
   logic [DATA_W-1:0]   req0_rdata_r;
   logic [DATA_W-1:0]   req1_rdata_r;

   logic                pend0_s;
   logic                pend1_s;
   logic                sel_s;
   logic                sel_wen_s;
   logic                sel_ren_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic                fin_ok_s;
   logic                fin_err_s;

   // Pending detection, round-robin selection and completion conditions
   always_comb begin
      // A requester whose done is high is still dropping its request
      pend0_s = (req0_wen | req0_ren) & ~req0_done_r;
      pend1_s = (req1_wen | req1_ren) & ~req1_done_r;

      if (pend0_s && pend1_s) begin
         sel_s = rr_r;
      end else if (pend1_s) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end

      if (sel_s) begin
         sel_wen_s   = req1_wen;
         sel_ren_s   = req1_ren;
         sel_addr_s  = req1_addr;
         sel_wdata_s = req1_wdata;
      end else begin
         sel_wen_s   = req0_wen;
         sel_ren_s   = req0_ren;
         sel_addr_s  = req0_addr;
         sel_wdata_s = req0_wdata;
      end

      if (state_r == ISSUE || state_r == WAIT) begin
         fin_ok_s = scan_ready;
      end else begin
         fin_ok_s = 1'b0;
      end

      if (TMO_EN && state_r == WAIT && !scan_ready && timer_r == TMO_LAST) begin
         fin_err_s = 1'b1;
      end else begin
         fin_err_s = 1'b0;
      end
   end

   // Arbitration state machine with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         rr_r         <= 1'b0;
         timer_r      <= 16'd0;
         grant_r      <= 1'b0;
         busy_r       <= 1'b0;
         scan_wen_r   <= 1'b0;
         scan_ren_r   <= 1'b0;
         scan_addr_r  <= {ADDR_W{1'b0}};
         scan_wdata_r <= {DATA_W{1'b0}};
         req0_done_r  <= 1'b0;
         req1_done_r  <= 1'b0;
         req0_err_r   <= 1'b0;
         req1_err_r   <= 1'b0;
         req0_rdata_r <= {DATA_W{1'b0}};
         req1_rdata_r <= {DATA_W{1'b0}};
      end else begin
         req0_done_r <= 1'b0;
         req1_done_r <= 1'b0;
         req0_err_r  <= 1'b0;
         req1_err_r  <= 1'b0;

         case (state_r)
            IDLE: begin
               if (pend0_s || pend1_s) begin
                  grant_r      <= sel_s;
                  scan_wen_r   <= sel_wen_s;
                  scan_ren_r   <= ~sel_wen_s & sel_ren_s;
                  scan_addr_r  <= sel_addr_s;
                  scan_wdata_r <= sel_wdata_s;
                  busy_r       <= 1'b1;
                  state_r      <= ISSUE;
               end
            end
            ISSUE: begin
               scan_wen_r   <= 1'b0;
               scan_ren_r   <= 1'b0;
               scan_addr_r  <= {ADDR_W{1'b0}};
               scan_wdata_r <= {DATA_W{1'b0}};
               if (!fin_ok_s) begin
                  timer_r <= 16'd0;
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (!fin_ok_s && !fin_err_s) begin
                  timer_r <= timer_r + 16'd1;
               end
            end
            default: begin
               state_r    <= IDLE;
               busy_r     <= 1'b0;
               scan_wen_r <= 1'b0;
               scan_ren_r <= 1'b0;
            end
         endcase

         // Completion, normal or timed out, returns the bus to IDLE
         if (fin_ok_s || fin_err_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            rr_r    <= ~grant_r;
            if (grant_r) begin
               req1_done_r  <= 1'b1;
               req1_err_r   <= fin_err_s;
               req1_rdata_r <= fin_ok_s ? scan_rdata : {DATA_W{1'b0}};
            end else begin
               req0_done_r  <= 1'b1;
               req0_err_r   <= fin_err_s;
               req0_rdata_r <= fin_ok_s ? scan_rdata : {DATA_W{1'b0}};
            end
         end
      end
   end

   assign req0_done  = req0_done_r;
   assign req0_err   = req0_err_r;
   assign req0_rdata = req0_rdata_r;
   assign req1_done  = req1_done_r;
   assign req1_err   = req1_err_r;
   assign req1_rdata = req1_rdata_r;
   assign scan_wen   = scan_wen_r;
   assign scan_ren   = scan_ren_r;
   assign scan_addr  = scan_addr_r;
   assign scan_wdata = scan_wdata_r;
   assign busy       = busy_r;
   assign grant      = grant_r;

endmodule

// File: tb/tb_scan_bus_arb.sv
// Directed and randomized bench for scan_bus_arb against a transaction-level model.
module tb_scan_bus_arb;

   logic        clk;
   logic        rst_n;
   logic        req0_wen, req0_ren, req1_wen, req1_ren;
   logic [14:0] req0_addr, req1_addr;
   logic [31:0] req0_wdata, req1_wdata;
   logic        req0_done, req1_done, req0_err, req1_err;
   logic [31:0] req0_rdata, req1_rdata;
   logic        scan_wen, scan_ren, scan_ready;
   logic [14:0] scan_addr;
   logic [31:0] scan_wdata, scan_rdata;
   logic        busy, grant;

   int total = 0;
   int bad   = 0;

   scan_bus_arb #(.ADDR_W(15), .DATA_W(32), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_wen(req0_wen), .req0_ren(req0_ren), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_wen(req1_wen), .req1_ren(req1_ren), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
      .scan_wen(scan_wen), .scan_ren(scan_ren), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
      .scan_rdata(scan_rdata), .scan_ready(scan_ready), .busy(busy), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model state for the randomized phase
   bit          act [2];
   bit          m_wen [2];
   bit          m_ren [2];
   logic [14:0] m_addr [2];
   logic [31:0] m_wd [2];
   logic [31:0] m_rd [2];
   bit          e_done [2];
   bit          dn [2];
   bit          m_out, owner, rr, m_grant, ready_now, p0, p1;
   bit          e_strobe, e_g, e_w, e_busy, e_grant;
   logic [14:0] e_addr;
   logic [31:0] e_wd;
   int          cnt;
   bit          ex;
   logic [1:0]  cmd;

   initial begin
      rst_n = 1'b0;
      req0_wen = 1'b0; req0_ren = 1'b0; req0_addr = 15'd0; req0_wdata = 32'd0;
      req1_wen = 1'b0; req1_ren = 1'b0; req1_addr = 15'd0; req1_wdata = 32'd0;
      scan_ready = 1'b0; scan_rdata = 32'd0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 1'b0);
      chk("rst_strobes", {scan_wen, scan_ren}, 2'b00);
      chk("rst_addr", scan_addr, 15'd0);
      chk("rst_wdata", scan_wdata, 32'd0);
      chk("rst_done", {req0_done, req1_done, req0_err, req1_err}, 4'b0000);
      chk("rst_rdata", {req0_rdata, req1_rdata}, 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Write from req0, ready three cycles after the strobe
      req0_wen = 1'b1; req0_addr = 15'h0012; req0_wdata = 32'hA5A5_0001;
      tick();
      chk("t1_wen", scan_wen, 1'b1);
      chk("t1_ren", scan_ren, 1'b0);
      chk("t1_addr", scan_addr, 15'h0012);
      chk("t1_wdata", scan_wdata, 32'hA5A5_0001);
      chk("t1_busy", busy, 1'b1);
      chk("t1_grant", grant, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t1_wen_drop", scan_wen, 1'b0);
         chk("t1_addr_zero", scan_addr, 15'd0);
         chk("t1_no_done", req0_done, 1'b0);
      end
      scan_ready = 1'b1; scan_rdata = 32'hCAFE_0003;
      tick();
      chk("t1_done", req0_done, 1'b1);
      chk("t1_err", req0_err, 1'b0);
      chk("t1_rdata", req0_rdata, 32'hCAFE_0003);
      chk("t1_req1_quiet", {req1_done, req1_err, req1_rdata}, 34'd0);
      req0_wen = 1'b0; scan_ready = 1'b0;
      tick();
      chk("t1_done_pulse", req0_done, 1'b0);
      chk("t1_idle", {busy, scan_wen}, 2'b00);

      // Read from req1, ready during the strobe
      req1_ren = 1'b1; req1_addr = 15'h7FFF;
      tick();
      chk("t2_ren", scan_ren, 1'b1);
      chk("t2_addr", scan_addr, 15'h7FFF);
      chk("t2_grant", grant, 1'b1);
      scan_ready = 1'b1; scan_rdata = 32'h1234_5678;
      tick();
      chk("t2_done", req1_done, 1'b1);
      chk("t2_rdata", req1_rdata, 32'h1234_5678);
      chk("t2_req0_held", {req0_done, req0_rdata}, {1'b0, 32'hCAFE_0003});
      req1_ren = 1'b0; scan_ready = 1'b0; scan_rdata = 32'd0;
      tick(); tick();
      chk("t2_rdata_held", req1_rdata, 32'h1234_5678);
      chk("t2_done_pulse", req1_done, 1'b0);

      // Both hold reads: grants alternate starting with req0
      req0_ren = 1'b1; req0_addr = 15'h0001;
      req1_ren = 1'b1; req1_addr = 15'h0002;
      ex = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t3_grant", grant, ex);
         chk("t3_ren", scan_ren, 1'b1);
         chk("t3_addr", scan_addr, ex ? 15'h0002 : 15'h0001);
         scan_ready = 1'b1; scan_rdata = 32'(i);
         tick();
         chk("t3_done", {req1_done, req0_done}, ex ? 2'b10 : 2'b01);
         chk("t3_no_dup", scan_ren, 1'b0);
         scan_ready = 1'b0;
         if (i == 3) begin
            req0_ren = 1'b0; req1_ren = 1'b0;
         end
         tick();
         ex = ~ex;
      end
      chk("t3_end_idle", {busy, scan_ren}, 2'b00);

      // wen and ren together issue a write only
      req0_wen = 1'b1; req0_ren = 1'b1; req0_addr = 15'h0055; req0_wdata = 32'h0000_DEAD;
      tick();
      chk("t4_wen", scan_wen, 1'b1);
      chk("t4_ren", scan_ren, 1'b0);
      chk("t4_grant", grant, 1'b0);
      scan_ready = 1'b1; scan_rdata = 32'h77;
      tick();
      chk("t4_done", req0_done, 1'b1);
      chk("t4_ren_done", scan_ren, 1'b0);
      req0_wen = 1'b0; req0_ren = 1'b0; scan_ready = 1'b0;
      tick();
      chk("t4_ren_after", scan_ren, 1'b0);

      // Timeout: done with err exactly 256 cycles after the strobe
      req0_ren = 1'b1; req0_addr = 15'h0100;
      tick();
      chk("t5_ren", scan_ren, 1'b1);
      for (int k = 1; k <= 255; k++) begin
         tick();
         chk("t5_wait", req0_done, 1'b0);
      end
      tick();
      chk("t5_done", req0_done, 1'b1);
      chk("t5_err", req0_err, 1'b1);
      chk("t5_rdata", req0_rdata, 32'd0);
      req0_ren = 1'b0; scan_ready = 1'b1; scan_rdata = 32'hFFFF;
      tick();
      chk("t5_stray", {req0_done, req0_err, busy}, 3'b000);
      chk("t5_stray_rdata", req0_rdata, 32'd0);
      scan_ready = 1'b0;
      tick();
      chk("t5_quiet", req0_done, 1'b0);

      // Reset in WAIT, then a fresh req1 request
      req0_ren = 1'b1; req0_addr = 15'h0003;
      tick(); tick(); tick();
      chk("t6_wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_busy", busy, 1'b0);
      chk("t6_async_rdata", {req0_rdata, req1_rdata}, 64'd0);
      chk("t6_async_misc", {grant, scan_wen, scan_ren, req0_done, req1_done}, 5'd0);
      req0_ren = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_idle", busy, 1'b0);
      req1_wen = 1'b1; req1_addr = 15'h0044; req1_wdata = 32'h0000_BEEF;
      tick();
      chk("t6_wen", scan_wen, 1'b1);
      chk("t6_grant", grant, 1'b1);
      chk("t6_addr", scan_addr, 15'h0044);
      scan_ready = 1'b1; scan_rdata = 32'h99;
      tick();
      chk("t6_done", {req1_done, req1_err, req1_rdata}, {1'b1, 1'b0, 32'h99});
      req1_wen = 1'b0; scan_ready = 1'b0;
      tick();

      // Randomized phase from a clean reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; m_wen[i] = 1'b0; m_ren[i] = 1'b0;
         m_addr[i] = 15'd0; m_wd[i] = 32'd0; m_rd[i] = 32'd0; e_done[i] = 1'b0;
      end
      m_out = 1'b0; owner = 1'b0; rr = 1'b0; m_grant = 1'b0; cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            dn[i] = e_done[i];
            if (dn[i]) act[i] = 1'b0;
            if (!act[i] && $urandom_range(0, 2) == 0) begin
               act[i] = 1'b1;
               cmd = 2'($urandom_range(1, 3));
               m_wen[i] = cmd[0];
               m_ren[i] = cmd[1];
               m_addr[i] = 15'($urandom);
               m_wd[i] = $urandom;
            end
         end
         req0_wen = act[0] & m_wen[0]; req0_ren = act[0] & m_ren[0];
         req0_addr = m_addr[0]; req0_wdata = m_wd[0];
         req1_wen = act[1] & m_wen[1]; req1_ren = act[1] & m_ren[1];
         req1_addr = m_addr[1]; req1_wdata = m_wd[1];

         ready_now = 1'b0;
         if (m_out) begin
            if (cnt == 0) ready_now = 1'b1;
            else cnt--;
         end else if ($urandom_range(0, 9) == 0) begin
            ready_now = 1'b1;
         end
         scan_ready = ready_now;
         scan_rdata = $urandom;

         e_done[0] = 1'b0; e_done[1] = 1'b0;
         if (m_out && ready_now) begin
            e_done[owner] = 1'b1;
            m_rd[owner] = scan_rdata;
         end
         e_strobe = 1'b0; e_g = 1'b0; e_w = 1'b0; e_addr = 15'd0; e_wd = 32'd0;
         if (!m_out) begin
            p0 = act[0] & ~dn[0];
            p1 = act[1] & ~dn[1];
            if (p0 || p1) begin
               e_strobe = 1'b1;
               e_g = (p0 && p1) ? rr : p1;
               e_w = m_wen[e_g];
               e_addr = m_addr[e_g];
               e_wd = m_wd[e_g];
            end
         end
         e_busy = (m_out && !ready_now) || e_strobe;
         e_grant = e_strobe ? e_g : m_grant;

         tick();
         chk("r_wen", scan_wen, e_strobe & e_w);
         chk("r_ren", scan_ren, e_strobe & ~e_w);
         chk("r_addr", scan_addr, e_addr);
         chk("r_wdata", scan_wdata, e_wd);
         chk("r_done", {req1_done, req0_done}, {e_done[1], e_done[0]});
         chk("r_err", {req1_err, req0_err}, 2'b00);
         chk("r_rdata0", req0_rdata, m_rd[0]);
         chk("r_rdata1", req1_rdata, m_rd[1]);
         chk("r_busy", busy, e_busy);
         chk("r_grant", grant, e_grant);

         if (e_done[0] || e_done[1]) begin
            m_out = 1'b0;
            rr = ~owner;
         end
         if (e_strobe) begin
            m_out = 1'b1;
            owner = e_g;
            m_grant = e_g;
            cnt = $urandom_range(0, 4);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
